// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch FSM encoding, reset PC default,
// instruction width and a PC alignment helper.
package proc_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Instruction PCs are word aligned; the low two bits are forced to zero.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: DEPTH entries of {pc, inst}, flush clears it in one cycle.
// Head data reads as zero while the queue is empty.
module fetch_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2 * INST_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         empty, full, do_wr, do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A write into a full queue is accepted only when the head leaves the same cycle.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  assign valid   = !empty;
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over any read or write in the same cycle.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; validity lives in the pointers and the output is masked when empty.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word reads to a synchronous ROM,
// tags returning data with its PC and buffers it for decode.
module fetch_ctrl
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ROM_AW   = 12,
  parameter int          QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              rom_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [31:0]       inst_pc
);

  localparam int CW = $clog2(QDEPTH);

  fetch_state_e        state_q, state_d;
  logic [31:0]         pc_q;
  logic [31:0]         req_pc_q;
  logic                inflight_q;
  logic [CW:0]         fifo_count;
  logic [2*INST_W-1:0] fifo_rdata;
  logic                credit_ok;
  logic                enq;
  logic                deq;

  // Credit: queued words plus the one possibly in flight must leave room.
  assign credit_ok = ({1'b0, fifo_count} + {{(CW+1){1'b0}}, inflight_q}) < (CW+2)'(QDEPTH);

  assign rom_addr = pc_q[ROM_AW+1:2];

  // Next state and request strobe; redirect suppresses the request.
  // NOTE: every output of this block is defaulted first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    rom_req = 1'b0;
    case (state_q)
      IDLE: if (fetch_en) state_d = RUN;
      RUN: begin
        if (!fetch_en) state_d = IDLE;
        else if (!redirect_valid && credit_ok) rom_req = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Fetch PC: redirect reloads it, each issued request advances it by one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= align_pc(redirect_pc);
    else if (rom_req)        pc_q <= pc_q + 32'd4;
  end

  // Track the outstanding request and remember its PC for tagging the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      inflight_q <= rom_req;
      if (rom_req) req_pc_q <= pc_q;
    end
  end

  // A response landing in the redirect cycle is dropped; no request is issued
  // in that cycle, so nothing stale can arrive the cycle after.
  assign enq = inflight_q && !redirect_valid;
  assign deq = inst_valid && inst_ready;

  fetch_fifo #(
    .DEPTH (QDEPTH),
    .W     (2 * INST_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (enq),
    .wr_data ({req_pc_q, rom_rdata}),
    .rd_en   (deq),
    .rd_data (fifo_rdata),
    .valid   (inst_valid),
    .count   (fifo_count)
  );

  assign inst_pc   = fifo_rdata[2*INST_W-1:INST_W];
  assign inst_data = fifo_rdata[INST_W-1:0];

endmodule
